// File: rtl/div_seq_32x32.sv
// div_seq_32x32: sequential restoring shift-subtract unsigned divider.
// One quotient bit is produced per SHIFT/SUB cycle pair; start/done handshake
// matches the companion shift-add multiplier so both can share a controller.
// Optional feature macro: DIV_ZERO_DETECT_EN. When it is defined, a zero divisor
// short-circuits to DONE with dz=1. When it is undefined, a zero divisor runs
// the full iteration and dz is tied low.
module div_seq_32x32 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dz
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // acc = {R[N:0], Q[N-1:0]}; R is one bit wider so the shift never overflows
    logic [2*N:0]  acc;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic [N:0]    diff;
    logic          r_ge;
    logic          zero_div;

`ifdef DIV_ZERO_DETECT_EN
    logic dz_flag;
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // Trial subtraction of the latched divisor from the partial remainder
    always_comb begin
        diff = acc[2*N:N] - {1'b0, dvs};
        r_ge = (acc[2*N:N] >= {1'b0, dvs});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; st is only looked at in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (st) state_next = zero_div ? DONE : SHIFT;
            SHIFT:   state_next = SUB;
            SUB:     state_next = (cnt == LAST) ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift, conditional subtract, iteration count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            dvs <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (st) begin
                        if (zero_div) acc <= {1'b0, dividend, {N{1'b1}}};
                        else          acc <= {{(N+1){1'b0}}, dividend};
                        dvs <= divisor;
                        cnt <= '0;
                    end
                end
                SHIFT: acc <= acc << 1;
                SUB: begin
                    if (r_ge) begin
                        acc[2*N:N] <= diff;
                        acc[0]     <= 1'b1;
                    end
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    // Remember whether the accepted operation was a divide-by-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  dz_flag <= 1'b0;
        else if (state == IDLE && st) dz_flag <= zero_div;
    end

    assign dz = dz_flag & done;
`else
    assign dz = 1'b0;
`endif

    assign done      = (state == DONE);
    assign quotient  = acc[N-1:0];
    assign remainder = acc[2*N-1:N];

endmodule

// File: tb/tb_div_seq_32x32.sv
// tb_div_seq_32x32: self-checking bench for div_seq_32x32 using directed cases
// and randomized operands checked against a plain-arithmetic reference model.
// Honours DIV_ZERO_DETECT_EN to choose the expected zero-divisor behaviour.
module tb_div_seq_32x32;

    logic        clk;
    logic        rst_n;
    logic        st;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dz;

    int checks = 0;
    int errors = 0;

    div_seq_32x32 #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st        (st),
        .dividend  (dividend),
        .divisor   (divisor),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD_EN = 1'b1;
`else
    localparam bit ZD_EN = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, with the algorithm's zero-divisor result
    task automatic refDiv(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output logic edz);
        if (b == 0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = ZD_EN ? 1 : 65;
            edz = ZD_EN;
        end else begin
            q   = a / b;
            r   = a % b;
            lat = 65;
            edz = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        st       = 1'b1;
        @(posedge clk);
        #1;
        st       = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int elat;
        logic [31:0] q;
        logic [31:0] r;
        logic edz;
        bit seen;
        applyStimulus(a, b);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        refDiv(a, b, q, r, elat, edz);
        checkOutput({tag, ".latency"}, 64'(lat), 64'(elat));
        if (seen) begin
            checkOutput({tag, ".quotient"}, 64'(quotient), 64'(q));
            checkOutput({tag, ".remainder"}, 64'(remainder), 64'(r));
            checkOutput({tag, ".dz"}, 64'(dz), 64'(edz));
            @(negedge clk);
            checkOutput({tag, ".done_pulse"}, 64'(done), 64'd0);
            checkOutput({tag, ".hold_q"}, 64'(quotient), 64'(q));
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic edz;
        int elat;
        int lat;
        int kind;

        rst_n    = 1'b0;
        st       = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.quotient", 64'(quotient), 64'd0);
        checkOutput("reset.remainder", 64'(remainder), 64'd0);
        checkOutput("reset.dz", 64'(dz), 64'd0);
        rst_n = 1'b1;

        runOp("t1", 32'd100, 32'd7);
        runOp("t2a", 32'hFFFF_FFFF, 32'd1);
        runOp("t2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("t3a", 32'd5, 32'd9);
        runOp("t3b", 32'd0, 32'd3);
        runOp("t4", 32'h1234, 32'd0);

        // Reset in the middle of a divide aborts it
        applyStimulus(32'hDEAD_BEEF, 32'h1234);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5.done", 64'(done), 64'd0);
        checkOutput("t5.quotient", 64'(quotient), 64'd0);
        checkOutput("t5.remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("t5.after", 32'hDEAD_BEEF, 32'h1234);

        // st held high, operands changed mid-divide, back-to-back second op
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        st       = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 20) begin
                dividend = 32'd77777;
                divisor  = 32'd123;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        checkOutput("t6.first_latency", 64'(lat), 64'd65);
        checkOutput("t6.first_quotient", 64'(quotient), 64'd333);
        checkOutput("t6.first_remainder", 64'(remainder), 64'd1);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                st  = 1'b0;
                break;
            end
        end
        st = 1'b0;
        checkOutput("t6.gap", 64'(lat), 64'd66);
        checkOutput("t6.second_quotient", 64'(quotient), 64'(32'd77777 / 32'd123));
        checkOutput("t6.second_remainder", 64'(remainder), 64'(32'd77777 % 32'd123));
        @(negedge clk);
        checkOutput("t6.idle", 64'(done), 64'd0);

        // Randomized operands with biased corner categories
        for (int n = 0; n < 500; n++) begin
            kind = int'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            case (kind)
                0: b = 32'd1;
                1: begin
                    if (b == 0) b = 32'd1;
                    a = a % b;
                end
                2: a = b;
                3: b = b >> $urandom_range(0, 31);
                default: b = b & 32'hFF;
            endcase
            applyStimulus(a, b);
            lat = 0;
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (done) begin
                    lat = i;
                    break;
                end
            end
            refDiv(a, b, q, r, elat, edz);
            checkOutput("rand.latency", 64'(lat), 64'(elat));
            checkOutput("rand.quotient", 64'(quotient), 64'(q));
            checkOutput("rand.remainder", 64'(remainder), 64'(r));
            checkOutput("rand.dz", 64'(dz), 64'(edz));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
